// File: rtl/perceptron_trainer.sv
// Execute-side training unit: queues lookup snapshots, pops on resolution, trains weights in two stages.
// Optional build macro PERCEPTRON_TRAIN_STATS_EN adds the train_count / flush_count outputs.
module perceptron_trainer #(
   parameter int DEPTH = 4,
   parameter int NW    = 12,
   parameter int WW    = 8,
   parameter int THETA = 37
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lu_valid,
   output logic             lu_ready,
   input  logic [31:0]      lu_pc,
   input  logic [NW*WW-1:0] lu_weights,
   input  logic [NW-1:0]    lu_ghr,
   input  logic [WW-1:0]    lu_sum,
   input  logic             res_valid,
   input  logic             res_taken,
   output logic             up_valid,
   output logic             up_wren,
   output logic [31:0]      up_pc4,
   output logic [NW*WW-1:0] up_data,
   output logic             up_dir,
   output logic             up_miss,
`ifdef PERCEPTRON_TRAIN_STATS_EN
   output logic [31:0]      train_count,
   output logic [31:0]      flush_count,
`endif
   output logic             err_underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [WW-1:0] W_MAX   = {1'b0, {(WW-1){1'b1}}};
   localparam logic [WW-1:0] W_MIN   = {1'b1, {(WW-1){1'b0}}};
   localparam logic [WW-1:0] W_ONE   = WW'(1);
   localparam logic [WW:0]   THETA_V = (WW+1)'(THETA);

   logic [31:0]      r_q_pc   [DEPTH];
   logic [NW*WW-1:0] r_q_w    [DEPTH];
   logic [NW-1:0]    r_q_ghr  [DEPTH];
   logic [WW-1:0]    r_q_sum  [DEPTH];
   logic             r_q_pred [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;

   logic             r_s1_valid, r_s1_miss, r_s1_train, r_s1_dir;
   logic [31:0]      r_s1_pc;
   logic [NW*WW-1:0] r_s1_w;
   logic [NW-1:0]    r_s1_ghr;

   logic             r_up_valid, r_up_wren, r_up_dir, r_up_miss, r_err;
   logic [31:0]      r_up_pc4;
   logic [NW*WW-1:0] r_up_data;

   logic [AW-1:0]    w_head, w_tail;
   logic             w_empty, w_full, w_pop, w_miss, w_flush, w_push, w_train;
   logic [WW-1:0]    w_sum;
   logic [WW:0]      w_sum_abs;
   logic [NW*WW-1:0] w_new_w;

   assign w_head  = r_rd_ptr[AW-1:0];
   assign w_tail  = r_wr_ptr[AW-1:0];
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_tail == w_head);
   assign w_pop   = res_valid & ~w_empty;
   assign w_miss  = r_q_pred[w_head] ^ res_taken;
   assign w_flush = w_pop & w_miss;
   // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
   assign w_push  = lu_valid & (~w_full | w_pop) & ~w_flush;
   assign w_sum   = r_q_sum[w_head];
   assign w_sum_abs = w_sum[WW-1] ? ({1'b0, ~w_sum} + (WW+1)'(1)) : {1'b0, w_sum};
   assign w_train = w_miss | (w_sum_abs <= THETA_V);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[w_tail]   <= lu_pc;
         r_q_w[w_tail]    <= lu_weights;
         r_q_ghr[w_tail]  <= lu_ghr;
         r_q_sum[w_tail]  <= lu_sum;
         r_q_pred[w_tail] <= ~lu_sum[WW-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         // Younger entries behind a mispredicted branch are wrong-path: drop them all.
         if (w_flush)
            r_wr_ptr <= r_rd_ptr + PW'(1);
         else if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (res_valid & w_empty)
            r_err <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < NW; gi++) begin : g_weight
      logic [WW-1:0] w_old;
      logic          w_up;
      assign w_old = r_s1_w[gi*WW +: WW];
      assign w_up  = (r_s1_ghr[gi] == r_s1_dir);
      assign w_new_w[gi*WW +: WW] = !r_s1_train ? w_old :
                                    w_up ? ((w_old == W_MAX) ? w_old : w_old + W_ONE) :
                                           ((w_old == W_MIN) ? w_old : w_old - W_ONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_miss  <= 1'b0;
         r_s1_train <= 1'b0;
         r_s1_dir   <= 1'b0;
         r_s1_pc    <= '0;
         r_s1_w     <= '0;
         r_s1_ghr   <= '0;
         r_up_valid <= 1'b0;
         r_up_wren  <= 1'b0;
         r_up_dir   <= 1'b0;
         r_up_miss  <= 1'b0;
         r_up_pc4   <= '0;
         r_up_data  <= '0;
      end else begin
         r_s1_valid <= w_pop;
         if (w_pop) begin
            r_s1_miss  <= w_miss;
            r_s1_train <= w_train;
            r_s1_dir   <= res_taken;
            r_s1_pc    <= r_q_pc[w_head];
            r_s1_w     <= r_q_w[w_head];
            r_s1_ghr   <= r_q_ghr[w_head];
         end
         r_up_valid <= r_s1_valid;
         r_up_wren  <= r_s1_valid & r_s1_train;
         r_up_dir   <= r_s1_valid & r_s1_dir;
         r_up_miss  <= r_s1_valid & r_s1_miss;
         r_up_pc4   <= r_s1_valid ? (r_s1_pc + 32'd4) : '0;
         r_up_data  <= r_s1_valid ? w_new_w : '0;
      end
   end

`ifdef PERCEPTRON_TRAIN_STATS_EN
   logic [31:0]   r_train_count, r_flush_count;
   logic [PW-1:0] w_count;
   assign w_count = r_wr_ptr - r_rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_train_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (r_s1_valid & r_s1_train)
            r_train_count <= r_train_count + 32'd1;
         // Discarded entries are those behind the popped head.
         if (w_flush)
            r_flush_count <= r_flush_count + 32'(w_count - PW'(1));
      end
   end

   assign train_count = r_train_count;
   assign flush_count = r_flush_count;
`endif

   assign lu_ready      = ~w_full;
   assign up_valid      = r_up_valid;
   assign up_wren       = r_up_wren;
   assign up_pc4        = r_up_pc4;
   assign up_data       = r_up_data;
   assign up_dir        = r_up_dir;
   assign up_miss       = r_up_miss;
   assign err_underflow = r_err;
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: queue-level behavioural model checked every cycle, plus directed literals.
module tb_perceptron_trainer;
   localparam int DEPTH = 4;
   localparam int NW    = 12;
   localparam int WW    = 8;
   localparam int THETA = 37;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             lu_valid = 1'b0;
   logic [31:0]      lu_pc = '0;
   logic [NW*WW-1:0] lu_weights = '0;
   logic [NW-1:0]    lu_ghr = '0;
   logic [WW-1:0]    lu_sum = '0;
   logic             res_valid = 1'b0;
   logic             res_taken = 1'b0;
   logic             lu_ready, up_valid, up_wren, up_dir, up_miss, err_underflow;
   logic [31:0]      up_pc4;
   logic [NW*WW-1:0] up_data;
`ifdef PERCEPTRON_TRAIN_STATS_EN
   logic [31:0]      train_count, flush_count;
`endif

   int checks   = 0;
   int failures = 0;

   perceptron_trainer #(.DEPTH(DEPTH), .NW(NW), .WW(WW), .THETA(THETA)) dut (
      .clk(clk), .reset(reset),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_pc(lu_pc), .lu_weights(lu_weights),
      .lu_ghr(lu_ghr), .lu_sum(lu_sum),
      .res_valid(res_valid), .res_taken(res_taken),
      .up_valid(up_valid), .up_wren(up_wren), .up_pc4(up_pc4), .up_data(up_data),
      .up_dir(up_dir), .up_miss(up_miss),
`ifdef PERCEPTRON_TRAIN_STATS_EN
      .train_count(train_count), .flush_count(flush_count),
`endif
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   typedef struct {
      logic [31:0]      pc;
      logic [NW*WW-1:0] w;
      logic [NW-1:0]    ghr;
      logic [WW-1:0]    sum;
   } snap_t;

   typedef struct {
      int               due;
      logic             wren;
      logic             miss;
      logic             dir;
      logic [31:0]      pc4;
      logic [NW*WW-1:0] data;
   } res_t;

   snap_t snap_q[$];
   res_t  sched_q[$];

   // Training rule in plain integer arithmetic: step each weight toward agreement, clamp to range.
   function automatic logic [NW*WW-1:0] new_weights(input snap_t s, input logic taken, input logic train);
      logic [NW*WW-1:0] d;
      int v;
      d = s.w;
      if (train) begin
         for (int i = 0; i < NW; i++) begin
            v = int'($signed(s.w[i*WW +: WW]));
            v = v + ((s.ghr[i] == taken) ? 1 : -1);
            if (v > (1 << (WW-1)) - 1) v = (1 << (WW-1)) - 1;
            if (v < -(1 << (WW-1)))    v = -(1 << (WW-1));
            d[i*WW +: WW] = v[WW-1:0];
         end
      end
      return d;
   endfunction

   int               cyc_n = 0;
   bit               model_ok = 1'b0;
   bit               m_err = 1'b0;
   int               sz, sumv, absv;
   bit               popped, flushed, pred;
   snap_t            s;
   res_t             r;
   logic             e_valid = 1'b0, e_wren = 1'b0, e_miss = 1'b0, e_dir = 1'b0;
   logic             e_ready = 1'b1, e_err = 1'b0;
   logic [31:0]      e_pc4 = '0;
   logic [NW*WW-1:0] e_data = '0;

   always @(posedge clk) begin
      cyc_n = cyc_n + 1;
      if (reset) begin
         snap_q.delete();
         sched_q.delete();
         m_err    = 1'b0;
         model_ok = 1'b1;
      end else begin
         sz      = snap_q.size();
         popped  = 1'b0;
         flushed = 1'b0;
         if (res_valid) begin
            if (sz == 0) begin
               m_err = 1'b1;
            end else begin
               s      = snap_q.pop_front();
               popped = 1'b1;
               sumv   = int'($signed(s.sum));
               absv   = (sumv < 0) ? -sumv : sumv;
               pred   = (sumv >= 0);
               r.due  = cyc_n + 1;
               r.miss = (pred != res_taken);
               r.wren = r.miss || (absv <= THETA);
               r.dir  = res_taken;
               r.pc4  = s.pc + 32'd4;
               r.data = new_weights(s, res_taken, r.wren);
               sched_q.push_back(r);
               if (r.miss) begin
                  snap_q.delete();
                  flushed = 1'b1;
               end
            end
         end
         if (lu_valid && (sz < DEPTH || popped) && !flushed) begin
            s.pc  = lu_pc;
            s.w   = lu_weights;
            s.ghr = lu_ghr;
            s.sum = lu_sum;
            snap_q.push_back(s);
         end
      end
      if (sched_q.size() > 0 && sched_q[0].due == cyc_n) begin
         r = sched_q.pop_front();
         e_valid = 1'b1; e_wren = r.wren; e_miss = r.miss; e_dir = r.dir;
         e_pc4 = r.pc4; e_data = r.data;
      end else begin
         e_valid = 1'b0; e_wren = 1'b0; e_miss = 1'b0; e_dir = 1'b0;
         e_pc4 = '0; e_data = '0;
      end
      e_ready = (snap_q.size() < DEPTH);
      e_err   = m_err;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("up_valid", 128'(up_valid), 128'(e_valid));
         chk("up_wren",  128'(up_wren),  128'(e_wren));
         chk("up_miss",  128'(up_miss),  128'(e_miss));
         chk("up_dir",   128'(up_dir),   128'(e_dir));
         chk("up_pc4",   128'(up_pc4),   128'(e_pc4));
         chk("up_data",  128'(up_data),  128'(e_data));
         chk("lu_ready", 128'(lu_ready), 128'(e_ready));
         chk("err_underflow", 128'(err_underflow), 128'(e_err));
         if (up_valid)
            $display("txn t=%0t pc4=%h wren=%b miss=%b dir=%b data=%h",
                     $time, up_pc4, up_wren, up_miss, up_dir, up_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit lv, input logic [31:0] pc, input logic [7:0] wb,
                        input logic [11:0] ghr, input logic [7:0] sum, input bit rv, input bit rt);
      lu_valid   = lv;
      lu_pc      = pc;
      lu_weights = {NW{wb}};
      lu_ghr     = ghr;
      lu_sum     = sum;
      res_valid  = rv;
      res_taken  = rt;
      tick();
      lu_valid  = 1'b0;
      res_valid = 1'b0;
   endtask

   logic [7:0] b_sum [6];
   bit         b_tk  [6];
   bit         b_wr  [6];
   bit         b_ms  [6];

   initial begin
      b_sum = '{8'h25, 8'h26, 8'hDB, 8'hDA, 8'h80, 8'h00};
      b_tk  = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
      b_wr  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
      b_ms  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};

      reset = 1'b1;
      tick();
      tick();
      chk("rst_valid", 128'(up_valid), 128'(1'b0));
      chk("rst_ready", 128'(lu_ready), 128'(1'b1));
      chk("rst_data",  128'(up_data),  128'(0));
      reset = 1'b0;

      // 1: confident correct prediction -> reported, no write
      drive(1, 32'h40, 8'h05, 12'hFFF, 8'h3C, 0, 0);
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("t1_valid", 128'(up_valid), 128'(1'b1));
      chk("t1_wren",  128'(up_wren),  128'(1'b0));
      chk("t1_miss",  128'(up_miss),  128'(1'b0));
      chk("t1_pc4",   128'(up_pc4),   128'(32'h44));

      // 2: low-confidence correct prediction trains
      drive(1, 32'h80, 8'h05, 12'h0F0, 8'h0A, 0, 0);
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("t2_wren", 128'(up_wren), 128'(1'b1));
      chk("t2_data", 128'(up_data), 128'(96'h04040404_06060606_04040404));

      // 3: saturation at both ends
      drive(1, 32'hC0, 8'h7F, 12'hFFF, 8'hFB, 0, 0);
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("t3_miss", 128'(up_miss), 128'(1'b1));
      chk("t3_wren", 128'(up_wren), 128'(1'b1));
      chk("t3_data_max", 128'(up_data), 128'({NW{8'h7F}}));
      drive(1, 32'hD0, 8'h80, 12'h000, 8'h80, 0, 0);
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("t3_data_min", 128'(up_data), 128'({NW{8'h80}}));

      // Threshold boundaries, including |-128|
      for (int i = 0; i < 6; i++) begin
         drive(1, 32'h1000 + 32'(i*16), 8'h05, 12'hFFF, b_sum[i], 0, 0);
         drive(0, 0, 8'h00, 12'h000, 8'h00, 1, b_tk[i]);
         tick();
         chk($sformatf("thr%0d_wren", i), 128'(up_wren), 128'(b_wr[i]));
         chk($sformatf("thr%0d_miss", i), 128'(up_miss), 128'(b_ms[i]));
      end

      // 4: fill, overflow push ignored, pop+push while full, drain in order
      drive(1, 32'h100, 8'h10, 12'hAAA, 8'h50, 0, 0);
      drive(1, 32'h104, 8'h11, 12'hAAA, 8'h50, 0, 0);
      drive(1, 32'h108, 8'h12, 12'hAAA, 8'h50, 0, 0);
      drive(1, 32'h10C, 8'h13, 12'hAAA, 8'h50, 0, 0);
      chk("t4_full", 128'(lu_ready), 128'(1'b0));
      drive(1, 32'h110, 8'h14, 12'hAAA, 8'h50, 0, 0);
      drive(1, 32'h200, 8'h20, 12'h555, 8'h50, 1, 1);
      chk("t4_still_full", 128'(lu_ready), 128'(1'b0));
      for (int i = 0; i < 4; i++)
         drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("t4_last_pc4", 128'(up_pc4), 128'(32'h204));

      // 5: oldest mispredicts -> flush, concurrent push dropped
      drive(1, 32'h300, 8'h05, 12'hFFF, 8'hF0, 0, 0);
      drive(1, 32'h304, 8'h05, 12'hFFF, 8'h50, 0, 0);
      drive(1, 32'h308, 8'h05, 12'hFFF, 8'h50, 0, 0);
      drive(1, 32'h30C, 8'h05, 12'hFFF, 8'h50, 1, 1);
      chk("t5_ready", 128'(lu_ready), 128'(1'b1));

      // 6: resolve on empty queue
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      chk("t6_err", 128'(err_underflow), 128'(1'b1));
      chk("t5_flush_pc4", 128'(up_pc4), 128'(32'h304));
      tick();
      chk("t6_no_valid", 128'(up_valid), 128'(1'b0));
      drive(1, 32'h400, 8'h05, 12'hFFF, 8'h50, 1, 1);
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("t6_push_kept", 128'(up_pc4), 128'(32'h404));

      // Reset with entries queued and a resolution in flight
      drive(1, 32'h500, 8'h05, 12'hFFF, 8'h50, 0, 0);
      drive(1, 32'h504, 8'h05, 12'hFFF, 8'h50, 0, 0);
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      reset = 1'b1;
      tick();
      chk("rst_mid_valid", 128'(up_valid), 128'(1'b0));
      chk("rst_mid_pc4",   128'(up_pc4),   128'(0));
      chk("rst_mid_err",   128'(err_underflow), 128'(1'b0));
      chk("rst_mid_ready", 128'(lu_ready), 128'(1'b1));
      reset = 1'b0;
      drive(0, 0, 8'h00, 12'h000, 8'h00, 1, 1);
      tick();
      chk("rst_discard_err", 128'(err_underflow), 128'(1'b1));
      chk("rst_discard_valid", 128'(up_valid), 128'(1'b0));

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
